weight_fetch_unit: RTL and testbench
====================================

Name: weight_fetch_unit

Overview:
- Streams a contiguous run of 100-bit packed weight words out of the 20000x100b weight SRAM into the conv/FC datapath.
- Each word is 25 weights x 4 bits.
- Drives the SRAM read port (active-low chip enable, 17-bit read address, registered read data) and absorbs its one-cycle read latency with a small skid FIFO.
- Presents words to the consumer over a valid/ready handshake, with backpressure-safe read issue.

Parameters:
- ADDR_W, 17, SRAM read address width
- DATA_W, 100, SRAM word width (25 x 4-bit weights)
- CNT_W, 15, width of the word-count field
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first SRAM word index of the run
- num_words  in  CNT_W  number of words to fetch
- busy  out  1  high from accepted start until the done cycle inclusive
- done  out  1  one-cycle pulse; last word has been accepted by the consumer
- sram_csb  out  1  SRAM chip enable, active low; low only on cycles issuing a read
- sram_raddr  out  ADDR_W  SRAM read address
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after the csb-low cycle
- w_valid  out  1  output word valid
- w_ready  in  1  consumer ready
- w_data  out  DATA_W  output weight word (FIFO head)
- w_last  out  1  high with the final word of the run

Behaviour:
- Reset values (asynchronous on rst_n low):
  - busy=0, done=0, sram_csb=1, sram_raddr=0, w_valid=0, w_last=0, w_data=0.
  - FIFO empty, in-flight flag 0, FSM in IDLE.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start with num_words != 0. Latch base_addr into the issue pointer and num_words into both the issue counter and the accept counter.
  - IDLE -> DONE on start with num_words == 0. No SRAM access. done pulses the next cycle.
  - FETCH -> DRAIN when the last read has been issued (issue counter reaches 0).
  - DRAIN -> DONE in the cycle the last word is accepted (w_valid & w_ready & w_last).
  - DONE -> IDLE unconditionally after 1 cycle. done=1 and busy=1 in DONE.
  - start outside IDLE is ignored. Inputs are not re-sampled mid-run.
- Read issue (FETCH only):
  - Issue when fifo_count + inflight + 1 <= FIFO_DEPTH, counting the pop occurring this cycle as freeing a slot only in the next cycle. This is a conservative credit check.
  - An issue cycle drives sram_csb=0 and sram_raddr = issue pointer. The issue pointer increments by 1 and the issue counter decrements by 1.
  - Non-issue cycles drive sram_csb=1. sram_raddr holds its last value.
  - At most one read per cycle. With w_ready held high, reads issue every cycle (full throughput).
- Data return:
  - inflight is set on an issue cycle. On the following cycle sram_rdata is written into the FIFO and inflight clears, unless a new issue re-sets it.
  - Read latency from csb low to w_valid is 2 cycles when the FIFO is empty: capture at edge 2, visible in the same cycle's output.
  - The FIFO never overflows by construction. An overflow attempt is a design error and is flagged by a bench assertion.
- Output handshake:
  - w_valid = FIFO non-empty.
  - w_data / w_last stay stable while w_valid & !w_ready.
  - Transfer occurs on w_valid & w_ready.
  - w_last is high for the entry whose accept counter value is 1.
  - Simultaneous push and pop keeps the count unchanged.
- Address arithmetic:
  - Pointer wraps modulo 2^ADDR_W with no error.
  - Runs reaching beyond index 19999 are the caller's responsibility and are not checked.
- Reset mid-run: all state returns to reset values immediately. In-flight SRAM data is discarded. No done pulse is generated.

Test Plan:
- base_addr=21, num_words=20, w_ready=1 constant -> reads at addresses 21..40 on 20 consecutive cycles; first w_valid 2 cycles after first csb low; 20 words in order; w_last on the 20th; done 1 cycle after it; busy low the next cycle.
- base_addr=1100, num_words=16, w_ready low for 10 cycles then high -> exactly 4 reads issued then csb held high; w_data stable while stalled; all 16 words delivered in order with no loss or duplication.
- num_words=0 -> sram_csb never low; done pulses 1 cycle after start; w_valid never high.
- num_words=1, base_addr=17100 -> single read at 17100; w_valid and w_last high together; done after accept.
- Random w_ready (50%) over num_words=200 from 17100 -> output sequence equals mem[17100..17299]; FIFO count never exceeds 4.
- rst_n pulsed low mid-run (after 5 words) -> outputs at reset values within the same cycle; a new start at base_addr=0 then runs cleanly with no stale words.

Source files
------------

// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: streams a contiguous run of packed weight words
// (25 x 4-bit weights per word) from the weight SRAM into the datapath.
// Read issue is credit-checked against a small skid FIFO, so the FIFO
// can absorb the SRAM's one-cycle read latency under any backpressure.
module weight_fetch_unit #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 100,
  parameter int CNT_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              sram_csb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int CSUM_W = PTR_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   issue_ptr_q;
  logic [CNT_W-1:0]    issue_cnt_q;
  logic [CNT_W-1:0]    accept_cnt_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic                rd_vld_p1;     // a read is in flight; its data is on sram_rdata this cycle
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FCNT_W-1:0]   fifo_cnt;

  logic                issue;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                credit_ok;
  logic [CSUM_W-1:0]   credit_sum;

  // Credit check uses the current occupancy only; a pop this cycle frees
  // its slot for the next cycle's decision, keeping the check conservative.
  assign credit_sum = CSUM_W'(fifo_cnt) + CSUM_W'(rd_vld_p1) + CSUM_W'(1);
  assign credit_ok  = (credit_sum <= CSUM_W'(FIFO_DEPTH));

  assign push       = rd_vld_p1;
  assign fifo_empty = (fifo_cnt == '0);
  assign w_valid    = !fifo_empty;
  assign pop        = w_valid && w_ready;
  assign w_data     = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign w_last     = w_valid && (accept_cnt_q == CNT_W'(1));

  assign sram_csb   = !issue;
  assign sram_raddr = issue ? issue_ptr_q : raddr_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_words == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue && (issue_cnt_q == CNT_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && w_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded outputs and read-issue decision
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    issue = (state_q == FETCH) && credit_ok;
  end

  // Stage p0 -> p1: issue pointer / counters and the in-flight read flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_ptr_q  <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      raddr_q      <= '0;
      rd_vld_p1    <= 1'b0;
    end else begin
      rd_vld_p1 <= issue;
      if ((state_q == IDLE) && start && (num_words != '0)) begin
        issue_ptr_q  <= base_addr;
        issue_cnt_q  <= num_words;
        accept_cnt_q <= num_words;
      end else begin
        if (issue) begin
          issue_ptr_q <= issue_ptr_q + ADDR_W'(1);
          issue_cnt_q <= issue_cnt_q - CNT_W'(1);
          raddr_q     <= issue_ptr_q;
        end
        if (pop) begin
          accept_cnt_q <= accept_cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Stage p1 -> p2: FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Stage p1 -> p2: capture returning SRAM data into the FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit with a registered SRAM model.
module tb_weight_fetch_unit;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 100;
  localparam int CNT_W  = 15;
  localparam int DEPTH  = 4;
  localparam int MAXC   = 2048;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_words = '0;
  logic              busy;
  logic              done;
  logic              sram_csb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  int vectors = 0;
  int miscompares = 0;

  weight_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .sram_csb(sram_csb),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] b;
    b = a * 17'd3;
    return {a, ~a, a ^ 17'h1ABCD, a + 17'd7, b, a[14:0] ^ 15'h2AAA};
  endfunction

  // Registered-read SRAM model
  always @(posedge clk) begin
    if (!sram_csb) sram_rdata <= pat(sram_raddr);
  end

  // FIFO occupancy / overflow monitor
  int max_fifo = 0;
  bit overflow_seen = 1'b0;
  always @(negedge clk) begin
    if (int'(dut.fifo_cnt) > max_fifo) max_fifo = int'(dut.fifo_cnt);
    if (rst_n && dut.rd_vld_p1 && (int'(dut.fifo_cnt) == DEPTH) && !(w_valid && w_ready))
      overflow_seen = 1'b1;
  end

  // Per-cycle capture of one job
  logic              cyc_csb   [MAXC];
  logic [ADDR_W-1:0] cyc_addr  [MAXC];
  logic              cyc_valid [MAXC];
  logic              cyc_ready [MAXC];
  logic [DATA_W-1:0] cyc_data  [MAXC];
  logic              cyc_last  [MAXC];
  logic              cyc_done  [MAXC];
  logic              cyc_busy  [MAXC];
  int ncyc;
  bit tmo;

  logic [ADDR_W-1:0] iss_addr[$];
  int                iss_t[$];
  logic [DATA_W-1:0] acc_data[$];
  logic              acc_last[$];
  int                acc_t[$];
  int first_valid_t;
  int done_t;
  int done_cnt;
  int valid_cnt;

  // mode 0: ready always high; 1: ready low for cycles 1..10 plus a stray start; 2: random ready
  task automatic run_job(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] n,
                         input int mode, input int budget);
    int t;
    bit seen_done;
    int dt;
    @(negedge clk);
    base_addr = base;
    num_words = n;
    start     = 1'b1;
    w_ready   = (mode == 0);
    tmo = 1'b0; seen_done = 1'b0; dt = 0; t = 0;
    while (1) begin
      @(negedge clk);
      t++;
      if (t >= MAXC || t > budget) begin tmo = 1'b1; break; end
      cyc_csb[t]   = sram_csb;
      cyc_addr[t]  = sram_raddr;
      cyc_valid[t] = w_valid;
      cyc_data[t]  = w_data;
      cyc_last[t]  = w_last;
      cyc_done[t]  = done;
      cyc_busy[t]  = busy;
      start     = (mode == 1 && t == 5);
      base_addr = 17'h1FFFF;
      num_words = 15'd7;
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (t > 10);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      cyc_ready[t] = w_ready;
      if (seen_done && t == dt + 1) break;
      if (done && !seen_done) begin seen_done = 1'b1; dt = t; end
    end
    start = 1'b0;
    w_ready = 1'b0;
    ncyc = tmo ? t - 1 : t;
  endtask

  task automatic extract();
    iss_addr.delete(); iss_t.delete();
    acc_data.delete(); acc_last.delete(); acc_t.delete();
    first_valid_t = -1; done_t = -1; done_cnt = 0; valid_cnt = 0;
    for (int t = 1; t <= ncyc; t++) begin
      if (!cyc_csb[t]) begin iss_addr.push_back(cyc_addr[t]); iss_t.push_back(t); end
      if (cyc_valid[t]) begin
        valid_cnt++;
        if (first_valid_t < 0) first_valid_t = t;
      end
      if (cyc_valid[t] && cyc_ready[t]) begin
        acc_data.push_back(cyc_data[t]); acc_last.push_back(cyc_last[t]); acc_t.push_back(t);
      end
      if (cyc_done[t]) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, sram_csb, w_valid, w_last} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/csb/valid/last=%b required 00100",
               {busy, done, sram_csb, w_valid, w_last});
    end
    vectors++;
    if (sram_raddr !== '0 || w_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: raddr=%0d w_data=%h required 0/0", sram_raddr, w_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    run_job(17'd21, 15'd20, 0, 200);
    extract();
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL stream_timeout: no done within budget"); end
    vectors++;
    if (iss_addr.size() != 20) begin
      miscompares++; $display("FAIL stream_issue_cnt: got %0d required 20", iss_addr.size());
    end
    for (int i = 0; i < iss_addr.size() && i < 20; i++) begin
      vectors++;
      if (iss_addr[i] !== 17'(21 + i) || iss_t[i] != 1 + i) begin
        miscompares++;
        $display("FAIL stream_issue[%0d]: addr=%0d cyc=%0d required addr=%0d cyc=%0d",
                 i, iss_addr[i], iss_t[i], 21 + i, 1 + i);
      end
    end
    vectors++;
    if (first_valid_t != 3) begin
      miscompares++; $display("FAIL stream_latency: first valid cyc=%0d required 3", first_valid_t);
    end
    vectors++;
    if (acc_data.size() != 20) begin
      miscompares++; $display("FAIL stream_word_cnt: got %0d required 20", acc_data.size());
    end
    for (int i = 0; i < acc_data.size() && i < 20; i++) begin
      vectors++;
      if (acc_data[i] !== pat(17'(21 + i)) || acc_last[i] !== (i == 19)) begin
        miscompares++;
        $display("FAIL stream_word[%0d]: data=%h last=%b required %h last=%b",
                 i, acc_data[i], acc_last[i], pat(17'(21 + i)), (i == 19));
      end
    end
    if (acc_t.size() == 20 && done_t > 0) begin
      vectors++;
      if (done_t != acc_t[19] + 1 || done_cnt != 1) begin
        miscompares++;
        $display("FAIL stream_done: done cyc=%0d count=%0d required cyc=%0d count=1",
                 done_t, done_cnt, acc_t[19] + 1);
      end
      vectors++;
      if (cyc_busy[done_t] !== 1'b1 || cyc_busy[done_t + 1] !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_busy: busy at done=%b after=%b required 1/0",
                 cyc_busy[done_t], cyc_busy[done_t + 1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int early;
    overflow_seen = 1'b0; max_fifo = 0;
    run_job(17'd1100, 15'd16, 1, 400);
    extract();
    early = 0;
    for (int i = 0; i < iss_t.size(); i++) if (iss_t[i] <= 10) early++;
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL bp_timeout: no done within budget"); end
    vectors++;
    if (early != 4) begin
      miscompares++; $display("FAIL bp_stall_issues: got %0d reads while stalled required 4", early);
    end
    vectors++;
    if (iss_addr.size() != 16) begin
      miscompares++; $display("FAIL bp_issue_cnt: got %0d required 16", iss_addr.size());
    end
    for (int t = 1; t < ncyc; t++) begin
      if (cyc_valid[t] && !cyc_ready[t]) begin
        vectors++;
        if (cyc_valid[t + 1] !== 1'b1 || cyc_data[t + 1] !== cyc_data[t] || cyc_last[t + 1] !== cyc_last[t]) begin
          miscompares++;
          $display("FAIL bp_stable cyc %0d: next valid=%b data=%h required valid=1 data=%h",
                   t, cyc_valid[t + 1], cyc_data[t + 1], cyc_data[t]);
        end
      end
    end
    vectors++;
    if (acc_data.size() != 16) begin
      miscompares++; $display("FAIL bp_word_cnt: got %0d required 16", acc_data.size());
    end
    for (int i = 0; i < acc_data.size() && i < 16; i++) begin
      vectors++;
      if (acc_data[i] !== pat(17'(1100 + i)) || acc_last[i] !== (i == 15)) begin
        miscompares++;
        $display("FAIL bp_word[%0d]: data=%h last=%b required %h last=%b",
                 i, acc_data[i], acc_last[i], pat(17'(1100 + i)), (i == 15));
      end
    end
    vectors++;
    if (overflow_seen || max_fifo > DEPTH) begin
      miscompares++; $display("FAIL bp_fifo: overflow=%b max=%0d required 0 and <=4", overflow_seen, max_fifo);
    end
  endtask

  task automatic test_zero_words();
    run_job(17'd55, 15'd0, 0, 50);
    extract();
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL zero_timeout: no done within budget"); end
    vectors++;
    if (iss_addr.size() != 0 || valid_cnt != 0) begin
      miscompares++;
      $display("FAIL zero_activity: reads=%0d valid cycles=%0d required 0/0", iss_addr.size(), valid_cnt);
    end
    vectors++;
    if (done_t != 1 || done_cnt != 1) begin
      miscompares++; $display("FAIL zero_done: done cyc=%0d count=%0d required 1/1", done_t, done_cnt);
    end
    vectors++;
    if (!tmo && (cyc_busy[1] !== 1'b1 || cyc_busy[2] !== 1'b0)) begin
      miscompares++; $display("FAIL zero_busy: busy=%b,%b required 1,0", cyc_busy[1], cyc_busy[2]);
    end
  endtask

  task automatic test_single_word();
    run_job(17'd17100, 15'd1, 0, 50);
    extract();
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL single_timeout: no done within budget"); end
    vectors++;
    if (iss_addr.size() != 1 || (iss_addr.size() == 1 && iss_addr[0] !== 17'd17100)) begin
      miscompares++; $display("FAIL single_issue: reads=%0d required one read at 17100", iss_addr.size());
    end
    vectors++;
    if (acc_data.size() != 1) begin
      miscompares++; $display("FAIL single_word_cnt: got %0d required 1", acc_data.size());
    end else begin
      vectors++;
      if (acc_data[0] !== pat(17'd17100) || acc_last[0] !== 1'b1 || acc_t[0] != first_valid_t) begin
        miscompares++;
        $display("FAIL single_word: data=%h last=%b required %h last=1", acc_data[0], acc_last[0], pat(17'd17100));
      end
      vectors++;
      if (done_t != acc_t[0] + 1) begin
        miscompares++; $display("FAIL single_done: done cyc=%0d required %0d", done_t, acc_t[0] + 1);
      end
    end
  endtask

  task automatic test_random_ready();
    overflow_seen = 1'b0; max_fifo = 0;
    run_job(17'd17100, 15'd200, 2, 1800);
    extract();
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL rand_timeout: no done within budget"); end
    vectors++;
    if (acc_data.size() != 200 || iss_addr.size() != 200) begin
      miscompares++;
      $display("FAIL rand_cnt: words=%0d reads=%0d required 200/200", acc_data.size(), iss_addr.size());
    end
    for (int i = 0; i < acc_data.size() && i < 200; i++) begin
      vectors++;
      if (acc_data[i] !== pat(17'(17100 + i)) || acc_last[i] !== (i == 199)) begin
        miscompares++;
        $display("FAIL rand_word[%0d]: data=%h last=%b required %h last=%b",
                 i, acc_data[i], acc_last[i], pat(17'(17100 + i)), (i == 199));
      end
    end
    vectors++;
    if (overflow_seen || max_fifo > DEPTH) begin
      miscompares++; $display("FAIL rand_fifo: overflow=%b max=%0d required 0 and <=4", overflow_seen, max_fifo);
    end
  endtask

  task automatic test_reset_mid_run();
    int got;
    int k;
    @(negedge clk);
    base_addr = 17'd300; num_words = 15'd20; start = 1'b1; w_ready = 1'b1;
    got = 0; k = 0;
    while (got < 5 && k < 60) begin
      @(negedge clk);
      start = 1'b0;
      if (w_valid && w_ready) got++;
      k++;
    end
    vectors++;
    if (got != 5) begin miscompares++; $display("FAIL mid_progress: words=%0d required 5", got); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sram_csb, w_valid, w_last} !== 5'b00100 || sram_raddr !== '0 || w_data !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: busy/done/csb/valid/last=%b raddr=%0d data=%h required 00100/0/0",
               {busy, done, sram_csb, w_valid, w_last}, sram_raddr, w_data);
    end
    @(negedge clk);
    rst_n = 1'b1; w_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_quiet: valid=%b busy=%b done=%b required 0/0/0", w_valid, busy, done);
    end
    run_job(17'd0, 15'd8, 0, 100);
    extract();
    vectors++;
    if (tmo || acc_data.size() != 8 || iss_addr.size() != 8) begin
      miscompares++;
      $display("FAIL mid_rerun_cnt: timeout=%b words=%0d reads=%0d required 0/8/8",
               tmo, acc_data.size(), iss_addr.size());
    end
    for (int i = 0; i < acc_data.size() && i < 8; i++) begin
      vectors++;
      if (acc_data[i] !== pat(17'(i)) || acc_last[i] !== (i == 7)) begin
        miscompares++;
        $display("FAIL mid_rerun_word[%0d]: data=%h last=%b required %h last=%b",
                 i, acc_data[i], acc_last[i], pat(17'(i)), (i == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_words();
    test_single_word();
    test_random_ready();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
